// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-master arbiter/sequencer for a single-port data RAM.
//            M0 (load/store unit) has priority. M1 (debug/loader) has
//            starvation protection and a bounded burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 16
) (
    input  logic        clk_100MHz,
    input  logic        arst_n,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        ram_r_ena_o,
    output logic [31:0] ram_r_addr_o,
    input  logic [31:0] ram_r_data_i,
    output logic        ram_w_ena_o,
    output logic [31:0] ram_w_addr_o,
    output logic [31:0] ram_w_data_o
);

    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int c_LOCK_W   = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        ST_ARB     = 1'b0,
        ST_M1_LOCK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_STARVE_W-1:0] w_starve_nxt;
    logic [c_LOCK_W-1:0]   r_lock_cnt;
    logic [c_LOCK_W-1:0]   w_lock_nxt;
    logic [c_LOCK_W-1:0]   w_lock_inc;

    logic                  w_starved;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_sel_we;
    logic [31:0]           w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic                  w_misal;
    logic                  w_rd_issue;
    logic                  w_wr_issue;

    logic                  r_m0_rvalid;
    logic                  r_m1_rvalid;
    logic                  r_m0_err;
    logic                  r_m1_err;
    logic [31:0]           r_m0_rdata;
    logic [31:0]           r_m1_rdata;
    logic [31:0]           r_waddr;
    logic [31:0]           r_wdata;

    assign w_starved  = (r_starve_cnt == c_STARVE_W'(STARVE_LIMIT));
    assign w_lock_inc = r_lock_cnt + c_LOCK_W'(1);

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= ST_ARB;
            r_starve_cnt <= '0;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_lock_cnt   <= w_lock_nxt;
        end
    end

    // Grants are suppressed while reset is asserted so no RAM access leaks out.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_cnt;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (arst_n) begin
            case (r_state)
                ST_ARB: begin
                    if (m0_req_i && !(w_starved && m1_req_i)) begin
                        w_gnt0 = 1'b1;
                    end else if (m1_req_i) begin
                        w_gnt1 = 1'b1;
                        if (m1_lock_i && (LOCK_MAX > 1)) begin
                            w_state_nxt = ST_M1_LOCK;
                            w_lock_nxt  = c_LOCK_W'(1);
                        end
                    end
                end
                ST_M1_LOCK: begin
                    if (!m1_req_i) begin
                        w_state_nxt = ST_ARB;
                        w_lock_nxt  = '0;
                    end else begin
                        w_gnt1     = 1'b1;
                        w_lock_nxt = w_lock_inc;
                        if (!m1_lock_i || (w_lock_inc == c_LOCK_W'(LOCK_MAX))) begin
                            w_state_nxt = ST_ARB;
                            w_lock_nxt  = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_ARB;
                    w_lock_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!m1_req_i || w_gnt1) begin
            w_starve_nxt = '0;
        end else if (!w_starved) begin
            w_starve_nxt = r_starve_cnt + c_STARVE_W'(1);
        end
    end

    assign w_any_gnt   = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? m1_we_i    : m0_we_i;
    assign w_sel_addr  = w_gnt1 ? m1_addr_i  : m0_addr_i;
    assign w_sel_wdata = w_gnt1 ? m1_wdata_i : m0_wdata_i;
    assign w_misal     = (w_sel_addr[1:0] != 2'b00);
    assign w_rd_issue  = w_any_gnt & ~w_sel_we & ~w_misal;
    assign w_wr_issue  = w_any_gnt &  w_sel_we & ~w_misal;

    // Responses are registered one cycle after grant; idle cycles return zero data.
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_m0_rvalid <= w_gnt0;
            r_m1_rvalid <= w_gnt1;
            r_m0_err    <= w_gnt0 & w_misal;
            r_m1_err    <= w_gnt1 & w_misal;
            r_m0_rdata  <= (w_gnt0 && w_rd_issue) ? ram_r_data_i : 32'h0;
            r_m1_rdata  <= (w_gnt1 && w_rd_issue) ? ram_r_data_i : 32'h0;
            if (w_wr_issue) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    assign m0_gnt_o     = w_gnt0;
    assign m1_gnt_o     = w_gnt1;
    assign m0_rvalid_o  = r_m0_rvalid;
    assign m1_rvalid_o  = r_m1_rvalid;
    assign m0_err_o     = r_m0_err;
    assign m1_err_o     = r_m1_err;
    assign m0_rdata_o   = r_m0_rdata;
    assign m1_rdata_o   = r_m1_rdata;

    assign ram_r_ena_o  = w_rd_issue;
    assign ram_r_addr_o = w_rd_issue ? w_sel_addr : 32'h0;
    // The write bus holds the last issued write; re-presenting it is harmless.
    assign ram_w_ena_o  = w_wr_issue;
    assign ram_w_addr_o = w_wr_issue ? w_sel_addr  : r_waddr;
    assign ram_w_data_o = w_wr_issue ? w_sel_wdata : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter: directed scenarios plus
//            randomized traffic against a behavioural arbitration/RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int LOCK_MAX     = 16;

    logic        clk_100MHz = 1'b0;
    logic        arst_n     = 1'b0;
    logic        m0_req_i   = 1'b0;
    logic        m0_we_i    = 1'b0;
    logic [31:0] m0_addr_i  = '0;
    logic [31:0] m0_wdata_i = '0;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i   = 1'b0;
    logic        m1_we_i    = 1'b0;
    logic [31:0] m1_addr_i  = '0;
    logic [31:0] m1_wdata_i = '0;
    logic        m1_lock_i  = 1'b0;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m1_rdata_o;
    logic        ram_r_ena_o, ram_w_ena_o;
    logic [31:0] ram_r_addr_o, ram_r_data_i, ram_w_addr_o, ram_w_data_o;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_100MHz  (clk_100MHz),
        .arst_n      (arst_n),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m0_err_o    (m0_err_o),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_lock_i   (m1_lock_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .m1_err_o    (m1_err_o),
        .ram_r_ena_o (ram_r_ena_o),
        .ram_r_addr_o(ram_r_addr_o),
        .ram_r_data_i(ram_r_data_i),
        .ram_w_ena_o (ram_w_ena_o),
        .ram_w_addr_o(ram_w_addr_o),
        .ram_w_data_o(ram_w_data_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // RAM stub: combinational read, write on rising edge.
    logic [31:0] ram_mem [256];
    bit          ram_init = 1'b0;
    always_comb ram_r_data_i = ram_mem[ram_r_addr_o[9:2]];
    always @(posedge clk_100MHz) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
            ram_init = 1'b1;
        end
        if (ram_w_ena_o) ram_mem[ram_w_addr_o[9:2]] = ram_w_data_o;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model state (written only by the compare process).
    int          m_starve = 0;
    int          m_lockn  = 0;
    bit          m_locked = 1'b0;
    bit          g0 = 1'b0, g1 = 1'b0;
    bit          e_rv0 = 1'b0, e_rv1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0;
    logic [31:0] e_rd0 = '0, e_rd1 = '0;
    logic [31:0] m_wa = '0, m_wd = '0;
    logic [31:0] m_mem [256];
    bit          m_init = 1'b0;
    bit          s_we, s_mis, s_rd, s_wr;
    logic [31:0] s_a, s_d;

    always @(negedge clk_100MHz) begin
        if (!m_init) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
            m_init = 1'b1;
        end
        if (!arst_n) begin
            chk("rst_flags", {24'h0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                              m0_err_o, m1_err_o, ram_r_ena_o, ram_w_ena_o}, 32'h0);
            chk("rst_m0_rdata", m0_rdata_o, 32'h0);
            chk("rst_m1_rdata", m1_rdata_o, 32'h0);
            chk("rst_w_addr", ram_w_addr_o, 32'h0);
            chk("rst_w_data", ram_w_data_o, 32'h0);
            m_starve = 0; m_lockn = 0; m_locked = 1'b0; g0 = 1'b0; g1 = 1'b0;
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
            m_wa = '0; m_wd = '0;
        end else begin
            chk("m0_rvalid", m0_rvalid_o, e_rv0);
            chk("m1_rvalid", m1_rvalid_o, e_rv1);
            if (e_rv0) begin
                chk("m0_rdata", m0_rdata_o, e_rd0);
                chk("m0_err", m0_err_o, e_err0);
            end
            if (e_rv1) begin
                chk("m1_rdata", m1_rdata_o, e_rd1);
                chk("m1_err", m1_err_o, e_err1);
            end
            // Who should own the RAM this cycle.
            g0 = 1'b0; g1 = 1'b0;
            if (m_locked) g1 = m1_req_i;
            else if (m0_req_i && !(m_starve == STARVE_LIMIT && m1_req_i)) g0 = 1'b1;
            else g1 = m1_req_i;
            chk("m0_gnt", m0_gnt_o, g0);
            chk("m1_gnt", m1_gnt_o, g1);
            s_we  = g1 ? m1_we_i : m0_we_i;
            s_a   = g1 ? m1_addr_i : m0_addr_i;
            s_d   = g1 ? m1_wdata_i : m0_wdata_i;
            s_mis = (s_a[1:0] != 2'b00);
            s_rd  = (g0 || g1) && !s_we && !s_mis;
            s_wr  = (g0 || g1) && s_we && !s_mis;
            chk("ram_r_ena", ram_r_ena_o, s_rd);
            if (s_rd) chk("ram_r_addr", ram_r_addr_o, s_a);
            chk("ram_w_ena", ram_w_ena_o, s_wr);
            if (s_wr) begin m_wa = s_a; m_wd = s_d; end
            chk("ram_w_addr", ram_w_addr_o, m_wa);
            chk("ram_w_data", ram_w_data_o, m_wd);
            e_rv0 = g0; e_rv1 = g1;
            e_err0 = g0 && s_mis; e_err1 = g1 && s_mis;
            e_rd0 = (g0 && s_rd) ? m_mem[s_a[9:2]] : 32'h0;
            e_rd1 = (g1 && s_rd) ? m_mem[s_a[9:2]] : 32'h0;
            if (s_wr) m_mem[s_a[9:2]] = s_d;
            if (!m1_req_i || g1) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
            if (!m_locked) begin
                if (g1 && m1_lock_i) begin
                    m_lockn  = 1;
                    m_locked = (m_lockn < LOCK_MAX);
                end
            end else if (!m1_req_i) begin
                m_locked = 1'b0;
            end else begin
                m_lockn++;
                if (!m1_lock_i || m_lockn >= LOCK_MAX) m_locked = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_100MHz);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req_i = req; m0_we_i = we; m0_addr_i = a; m0_wdata_i = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic lock,
                          input logic [31:0] a, input logic [31:0] d);
        m1_req_i = req; m1_we_i = we; m1_lock_i = lock; m1_addr_i = a; m1_wdata_i = d;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned base;
        int unsigned off;
        base = $urandom_range(0, 15) * 4;
        off  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        return 32'(base + off);
    endfunction

    initial begin
        repeat (3) tick();
        arst_n = 1'b1;

        // Write then read back on M0.
        set_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        neg(); chk("t1_wr_gnt", m0_gnt_o, 1); chk("t1_wr_ena", ram_w_ena_o, 1);
        tick(); set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        neg(); chk("t1_rd_gnt", m0_gnt_o, 1); chk("t1_wr_rvalid", m0_rvalid_o, 1);
        chk("t1_rd_ena", ram_r_ena_o, 1);
        tick(); set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        neg(); chk("t1_rd_rvalid", m0_rvalid_o, 1); chk("t1_rdata", m0_rdata_o, 32'hDEADBEEF);

        // Write bus holds after the write.
        tick(); set_m0(1'b1, 1'b1, 32'h20, 32'h55);
        neg(); chk("t6_gnt", m0_gnt_o, 1);
        tick(); set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            neg(); chk("t6_w_ena", ram_w_ena_o, 0);
            chk("t6_w_addr", ram_w_addr_o, 32'h20); chk("t6_w_data", ram_w_data_o, 32'h55);
            tick();
        end

        // Misaligned read.
        set_m0(1'b1, 1'b0, 32'h12, 32'h0);
        neg(); chk("t4_gnt", m0_gnt_o, 1); chk("t4_r_ena", ram_r_ena_o, 0);
        tick(); set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        neg(); chk("t4_rvalid", m0_rvalid_o, 1); chk("t4_err", m0_err_o, 1);
        chk("t4_rdata", m0_rdata_o, 32'h0);

        // Starvation: 8 M0 grants, then M1, repeating.
        tick(); set_m0(1'b1, 1'b0, 32'h10, 32'h0); set_m1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 18; i++) begin
            neg();
            chk("t2_m0_gnt", m0_gnt_o, (i == 8 || i == 17) ? 0 : 1);
            chk("t2_m1_gnt", m1_gnt_o, (i == 8 || i == 17) ? 1 : 0);
            tick();
        end
        set_m0(1'b0, 1'b0, 32'h0, 32'h0); set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Full lock burst: 16 M1 grants, then M0.
        set_m1(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        neg(); chk("t3_first_m1", m1_gnt_o, 1);
        tick(); set_m0(1'b1, 1'b0, 32'h44, 32'h0);
        for (int i = 1; i < LOCK_MAX; i++) begin
            neg(); chk("t3_lock_m1", m1_gnt_o, 1); chk("t3_lock_m0", m0_gnt_o, 0);
            tick();
        end
        neg(); chk("t3_after_m0", m0_gnt_o, 1); chk("t3_after_m1", m1_gnt_o, 0);
        tick(); set_m0(1'b0, 1'b0, 32'h0, 32'h0); set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Lock released by lock=0 on the third grant.
        set_m1(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        neg(); chk("t3b_g1", m1_gnt_o, 1);
        tick(); set_m0(1'b1, 1'b0, 32'h44, 32'h0);
        neg(); chk("t3b_g2", m1_gnt_o, 1);
        tick(); m1_lock_i = 1'b0;
        neg(); chk("t3b_g3", m1_gnt_o, 1);
        tick();
        neg(); chk("t3b_g4_m0", m0_gnt_o, 1);
        tick(); set_m0(1'b0, 1'b0, 32'h0, 32'h0); set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset during lock with a read in flight.
        set_m1(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        neg(); chk("t5_g1", m1_gnt_o, 1);
        tick();
        neg(); chk("t5_g2", m1_gnt_o, 1);
        #1 arst_n = 1'b0;
        neg(); chk("t5_no_rvalid", m1_rvalid_o, 0); chk("t5_no_gnt", m1_gnt_o, 0);
        chk("t5_no_rena", ram_r_ena_o, 0);
        tick(); arst_n = 1'b1;
        set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        neg(); chk("t5_m0_gnt", m0_gnt_o, 1);
        tick(); set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        neg(); chk("t5_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
        tick();

        // Random traffic; requesters hold until the model says they were granted.
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req_i || g0)
                set_m0(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, rand_addr(), $urandom());
            if (!m1_req_i || g1)
                set_m1(($urandom_range(0, 9) < 5), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) != 0, rand_addr(), $urandom());
            tick();
        end
        set_m0(1'b0, 1'b0, 32'h0, 32'h0); set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
